// File: rtl/i2c_scl_clock.sv
// I2C SCL clock generator: open-drain SCL from a phase counter, with slave
// clock stretching, multi-master resynchronisation and stuck-low detection.
module i2c_scl_clock #(
  parameter int COUNTER_END      = 5,
  parameter int COUNTER_RISE     = COUNTER_END / 2,
  parameter int MULTI_MASTER     = 0,
  parameter int CLOCK_STRETCHING = 0,
  parameter int WAIT_END         = 100
) (
  input  logic                           clk_in,
  input  logic                           reset,
  inout  wire                            scl,
  output logic                           bus_clear,
  output logic [$clog2(COUNTER_END)-1:0] counter
);

  localparam int CW = $clog2(COUNTER_END);
  localparam int SW = $clog2(WAIT_END + 1);

  localparam logic [CW-1:0] RISE   = CW'(COUNTER_RISE);
  localparam logic [CW-1:0] END_M1 = CW'(COUNTER_END - 1);
  localparam logic [SW-1:0] WAIT_M = SW'(WAIT_END);

  logic [CW-1:0] counter_q, counter_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          bus_clear_q, bus_clear_d;
  logic          scl_low;
  logic          stretch_hold;
  logic          resync;

  // Open drain: only ever pull low; a floating line reads as high.
  assign scl     = (counter_q < RISE) ? 1'b0 : 1'bz;
  assign scl_low = (scl == 1'b0);

  assign stretch_hold = (CLOCK_STRETCHING != 0) && (counter_q == RISE) && scl_low;
  assign resync       = (MULTI_MASTER != 0) && (counter_q > RISE) && scl_low;

  always_comb begin
    counter_d   = counter_q + 1'b1;
    stretch_d   = stretch_q;
    bus_clear_d = 1'b0;

    if (counter_q < RISE) begin
      counter_d = counter_q + 1'b1;
    end else if (stretch_hold) begin
      counter_d = counter_q;
    end else if (resync) begin
      counter_d = '0;
    end else if (counter_q == END_M1) begin
      counter_d = '0;
    end

    if (stretch_hold) begin
      if (stretch_q != WAIT_M) stretch_d = stretch_q + 1'b1;
    end else if (!scl_low) begin
      stretch_d = '0;
    end

    // Flag from the next stretch count so the flag lands on the reaching edge.
    bus_clear_d = (CLOCK_STRETCHING != 0) && (stretch_d == WAIT_M);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      counter_q   <= '0;
      stretch_q   <= '0;
      bus_clear_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      stretch_q   <= stretch_d;
      bus_clear_q <= bus_clear_d;
    end
  end

  assign counter   = counter_q;
  assign bus_clear = bus_clear_q;

endmodule

// File: tb/tb_i2c_scl_clock.sv
// Randomised and directed bench for i2c_scl_clock against a cycle-level model.
module tb_i2c_scl_clock;

  localparam int CEND  = 5;
  localparam int CRISE = 2;
  localparam int WEND  = 100;

  logic       clk_in;
  logic       reset;
  logic       ext_low;
  logic       bus_clear;
  logic [2:0] counter;
  wire        scl;

  pullup (scl);
  assign scl = ext_low ? 1'b0 : 1'bz;

  i2c_scl_clock #(
    .COUNTER_END(CEND), .COUNTER_RISE(CRISE), .MULTI_MASTER(1),
    .CLOCK_STRETCHING(1), .WAIT_END(WEND)
  ) dut (
    .clk_in(clk_in), .reset(reset), .scl(scl),
    .bus_clear(bus_clear), .counter(counter)
  );

  initial begin
    clk_in = 1'b0;
    forever #2 clk_in = ~clk_in;
  end

  int n_vec = 0;
  int n_err = 0;

  // model state: phase, consecutive stretched edges, flag
  int m_cnt = 0;
  int m_st  = 0;
  int m_bc  = 0;
  bit arm_timer = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock edge of behaviour given the line level seen at that edge.
  function automatic void model_step(input bit rst, input bit line_low);
    bit stretching;
    if (rst) begin
      m_cnt = 0; m_st = 0; m_bc = 0;
      return;
    end
    stretching = (m_cnt == CRISE) && line_low;
    if (m_cnt < CRISE)                 m_cnt = m_cnt + 1;
    else if (stretching)               ;
    else if (line_low && m_cnt > CRISE) m_cnt = 0;
    else                               m_cnt = (m_cnt + 1) % CEND;
    if (stretching)     m_st = (m_st + 1 > WEND) ? WEND : m_st + 1;
    else if (!line_low) m_st = 0;
    m_bc = (m_st == WEND) ? 1 : 0;
  endfunction

  task automatic step(input bit rst, input bit low);
    bit line_low;
    @(negedge clk_in);
    reset   = rst;
    ext_low = low;
    if (arm_timer) begin
      arm_timer = 0;
      fork
        begin
          #400 check_val("bus_clear_at_400", {31'b0, bus_clear}, 0);
          #8   check_val("bus_clear_at_408", {31'b0, bus_clear}, 1);
        end
      join_none
    end
    line_low = low || (m_cnt < CRISE);
    model_step(rst, line_low);
    @(posedge clk_in);
    #1;
    check_val("counter", {29'b0, counter}, m_cnt);
    check_val("bus_clear", {31'b0, bus_clear}, m_bc);
    check_val("scl", {31'b0, scl}, (ext_low || m_cnt < CRISE) ? 0 : 1);
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while (m_cnt != ph && k < 12) begin
      step(0, 0);
      k++;
    end
    check_val("phase_reached", m_cnt, ph);
  endtask

  initial begin
    int burst;
    reset   = 1'b1;
    ext_low = 1'b0;

    step(1, 0);
    step(1, 0);
    check_val("reset_counter", {29'b0, counter}, 0);
    check_val("reset_scl_low", {31'b0, scl}, 0);

    // free run
    for (int i = 0; i < 20; i++) step(0, 0);

    // long stretch into bus_clear, driven at the falling edge while counter=1
    wait_phase(1);
    arm_timer = 1;
    for (int i = 0; i < 110; i++) step(0, 1);
    check_val("stretch_hold_counter", {29'b0, counter}, CRISE);
    check_val("bus_clear_set", {31'b0, bus_clear}, 1);
    step(0, 0);
    check_val("release_clears", {31'b0, bus_clear}, 0);
    check_val("release_counter", {29'b0, counter}, 3);
    step(0, 0);
    check_val("resume_4", {29'b0, counter}, 4);
    step(0, 0);
    check_val("resume_0", {29'b0, counter}, 0);

    // multi-master resync in the released phase
    wait_phase(3);
    step(0, 1);
    check_val("resync_counter", {29'b0, counter}, 0);
    check_val("resync_scl", {31'b0, scl}, 0);
    step(0, 0);

    // short stretch of three edges
    wait_phase(1);
    step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    check_val("short_hold", {29'b0, counter}, CRISE);
    step(0, 0);
    check_val("short_advance", {29'b0, counter}, 3);
    check_val("short_no_bc", {31'b0, bus_clear}, 0);

    // reset during a stretch
    wait_phase(1);
    for (int i = 0; i < 6; i++) step(0, 1);
    step(1, 1);
    check_val("rst_stretch_counter", {29'b0, counter}, 0);
    check_val("rst_stretch_bc", {31'b0, bus_clear}, 0);
    step(0, 0);

    // random bursts of external low, occasional resets
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 3) == 0)
        burst = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 6);
      step(($urandom_range(0, 299) == 0), burst > 0);
      if (burst > 0) burst--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
